// File: rtl/clock_enable_gen_pkg.sv
// ---------------------------------------------------------------------------
// clock_gen_pkg
// Shared constants, the divide-ratio type and the effective-ratio helper for
// the clock_enable_gen block and its channels.
//   N_CH_DEF        : default number of output channels
//   DIV_W_DEF       : default divide-ratio / counter width
//   DEFAULT_DIV_DEF : ratio every channel holds after reset
//   div_t           : divide-ratio type at the default width
//   eff_div()       : maps a programmed ratio of 0 onto 1
// ---------------------------------------------------------------------------
package clock_gen_pkg;

   localparam int N_CH_DEF        = 4;
   localparam int DIV_W_DEF       = 16;
   localparam int DEFAULT_DIV_DEF = 2;

   typedef logic [DIV_W_DEF-1:0] div_t;

   // A programmed ratio of zero would never wrap, so it behaves as divide-by-1.
   function automatic div_t eff_div(input div_t d);
      return (d == '0) ? div_t'(1) : d;
   endfunction

endpackage

// File: rtl/clock_enable_gen_if.sv
// ---------------------------------------------------------------------------
// clock_enable_gen_if
// Valid/ready configuration channel used to reprogram one divider channel.
//   cfg_valid : request from the master
//   cfg_ready : accept from the slave (transfer on valid && ready at an edge)
//   cfg_ch    : target channel index
//   cfg_div   : new divide ratio
// ---------------------------------------------------------------------------
interface clock_enable_gen_if
   import clock_gen_pkg::*;
#(
   parameter int N_CH  = N_CH_DEF,
   parameter int DIV_W = DIV_W_DEF,
   parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;

   modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);

endinterface

// File: rtl/clock_enable_gen_channel.sv
// ---------------------------------------------------------------------------
// clock_div_channel
// One divider channel: free-running counter, current and pending ratio,
// registered strobe and square wave, and the "has strobed" seen bit.
//   clk_in, rst_n : fabric clock, synchronous active-low reset
//   resync        : realign counter to zero, apply any pending ratio now
//   load/load_div : accepted config write for this channel
//   ce_out        : one-cycle strobe, period D
//   div_out       : square wave, high floor(D/2) cycles then low ceil(D/2)
//   seen          : channel has strobed since the last disturbance
//   apply         : ratio update takes effect at this edge
//   pend_busy     : an update is waiting for the end of the current period
// ---------------------------------------------------------------------------
module clock_div_channel #(
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             resync,
   input  logic             load,
   input  logic [DIV_W-1:0] load_div,
   output logic             ce_out,
   output logic             div_out,
   output logic             seen,
   output logic             apply,
   output logic             pend_busy
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cur_div;
   logic [DIV_W-1:0] pend_div;
   logic [DIV_W-1:0] eff;
   logic             pend;
   logic             ce_q;
   logic             div_q;
   logic             seen_q;
   logic             wrap;

   // A ratio of zero is treated as divide-by-1; wrap marks the last count
   // of the current period, the only point where a new ratio may take over.
   assign eff   = (cur_div == '0) ? DIV_W'(1) : cur_div;
   assign wrap  = (cnt == eff - DIV_W'(1));
   assign apply = resync ? (pend | load) : (wrap & pend);

   assign ce_out    = ce_q;
   assign div_out   = div_q;
   assign pend_busy = pend;
   // The strobe currently on the output already counts as seen, so lock can
   // be reported one cycle after the strobe rather than two.
   assign seen      = seen_q | ce_q;

   // Counter, ratio and output registers. Resync realigns everything at
   // once; otherwise a pending ratio is only swapped in at the wrap so the
   // running period always finishes at the old ratio without a short pulse.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         cnt      <= '0;
         cur_div  <= DIV_W'(DEFAULT_DIV);
         pend_div <= '0;
         pend     <= 1'b0;
         ce_q     <= 1'b0;
         div_q    <= 1'b0;
         seen_q   <= 1'b0;
      end else if (resync) begin
         cnt    <= '0;
         ce_q   <= 1'b0;
         div_q  <= 1'b0;
         seen_q <= 1'b0;
         pend   <= 1'b0;
         if (load) begin
            cur_div <= load_div;
         end else if (pend) begin
            cur_div <= pend_div;
         end
      end else begin
         ce_q   <= wrap;
         div_q  <= (cnt < (eff >> 1));
         seen_q <= (wrap && pend) ? 1'b0 : (seen_q | ce_q);
         if (wrap) begin
            cnt <= '0;
            if (pend) begin
               cur_div <= pend_div;
               pend    <= 1'b0;
            end
         end else begin
            cnt <= cnt + DIV_W'(1);
         end
         if (load) begin
            pend     <= 1'b1;
            pend_div <= load_div;
         end
      end
   end

endmodule

// File: rtl/clock_enable_gen.sv
// ---------------------------------------------------------------------------
// clock_enable_gen
// N_CH independent clock-enable / divided square-wave generators running
// off one fabric clock, with ratios reprogrammable through a valid/ready port.
//   clk_in  : fabric clock
//   rst_n   : synchronous active-low reset
//   cfg     : configuration port (slave side)
//   resync  : realign all channel phases
//   ce_out  : per-channel one-cycle strobe
//   div_out : per-channel divided square wave
//   locked  : every channel has strobed since the last disturbance
// ---------------------------------------------------------------------------
module clock_enable_gen
   import clock_gen_pkg::*;
#(
   parameter int N_CH        = N_CH_DEF,
   parameter int DIV_W       = DIV_W_DEF,
   parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic              clk_in,
   input  logic              rst_n,
   clock_enable_gen_if.slave cfg,
   input  logic              resync,
   output logic [N_CH-1:0]   ce_out,
   output logic [N_CH-1:0]   div_out,
   output logic              locked
);

   logic            ready_q;
   logic            locked_q;
   logic            accept;
   logic            ch_in_range;
   logic [N_CH-1:0] load;
   logic [N_CH-1:0] seen;
   logic [N_CH-1:0] apply;
   logic [N_CH-1:0] pend_busy;

   assign cfg.cfg_ready = ready_q;
   assign locked        = locked_q;
   assign accept        = cfg.cfg_valid && ready_q;
   // Out-of-range channel numbers are accepted but steer no channel.
   assign ch_in_range   = (int'(cfg.cfg_ch) < N_CH);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign load[i] = accept && ch_in_range && (int'(cfg.cfg_ch) == i);

      clock_div_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in    (clk_in),
         .rst_n     (rst_n),
         .resync    (resync),
         .load      (load[i]),
         .load_div  (cfg.cfg_div),
         .ce_out    (ce_out[i]),
         .div_out   (div_out[i]),
         .seen      (seen[i]),
         .apply     (apply[i]),
         .pend_busy (pend_busy[i])
      );
   end

   // Only one update may be outstanding: ready drops on a real accept and
   // comes back on the edge where no channel is left holding a pending
   // ratio. Resync applies everything at once, so ready returns immediately.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         ready_q <= 1'b1;
      end else if (resync) begin
         ready_q <= 1'b1;
      end else if (accept && ch_in_range) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= ~|(pend_busy & ~apply);
      end
   end

   // Lock is the registered AND of every channel's seen bit.
   always_ff @(posedge clk_in) begin
      if (!rst_n || resync) begin
         locked_q <= 1'b0;
      end else begin
         locked_q <= &seen;
      end
   end

endmodule
